// File: rtl/fft_bin_streamer.sv
// Frame buffer behind the 8-point FFT: bit-reverse reorder, one bin per beat,
// approximate magnitude alongside each bin.
module fft_bin_streamer #(
    parameter int DW     = 11,
    parameter int N      = 8,
    parameter int BITREV = 1,
    parameter int MW     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [N*DW-1:0]      bin_real_flat,
    input  logic [N*DW-1:0]      bin_imag_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_index,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic [MW-1:0]        out_mag,
    output logic                 out_last,
    output logic [7:0]           frame_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state;
    logic signed [DW-1:0] buf_re [N];
    logic signed [DW-1:0] buf_im [N];
    logic                 xfer;
    logic                 accept;
    logic [2:0]           nxt;
    logic signed [DW-1:0] sel_re;
    logic signed [DW-1:0] sel_im;
    logic [MW-1:0]        sel_mag;

    function automatic logic [2:0] slot_pos(input logic [2:0] k);
        return (BITREV != 0) ? {k[0], k[1], k[2]} : k;
    endfunction

    // alpha-max-beta-min with alpha=1, beta=1/2; one extra bit keeps |-2^(DW-1)| exact
    function automatic logic [MW-1:0] mag_of(
        input logic signed [DW-1:0] re,
        input logic signed [DW-1:0] im
    );
        logic signed [DW:0] rs;
        logic signed [DW:0] is;
        logic [DW:0]        a;
        logic [DW:0]        b;
        logic [DW:0]        hi;
        logic [DW:0]        lo;
        rs = {re[DW-1], re};
        is = {im[DW-1], im};
        a  = rs[DW] ? -rs : rs;
        b  = is[DW] ? -is : is;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        return MW'(hi) + MW'(lo >> 1);
    endfunction

    assign xfer        = out_valid && out_ready;
    assign out_last    = out_valid && (out_index == 3'd7);
    assign frame_ready = (state == IDLE) || (xfer && out_last);
    assign accept      = frame_valid && frame_ready;
    assign nxt         = out_index + 3'd1;

    // Natural bin 0 always comes from input slot 0, so a fresh frame bypasses the buffer
    always_comb begin
        sel_re = buf_re[nxt];
        sel_im = buf_im[nxt];
        if (accept) begin
            sel_re = bin_real_flat[DW-1:0];
            sel_im = bin_imag_flat[DW-1:0];
        end
    end

    assign sel_mag = mag_of(sel_re, sel_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_index   <= 3'd0;
            out_real    <= '0;
            out_imag    <= '0;
            out_mag     <= '0;
            frame_count <= 8'd0;
            for (int k = 0; k < N; k++) begin
                buf_re[k] <= '0;
                buf_im[k] <= '0;
            end
        end else begin
            if (xfer && out_last)
                frame_count <= frame_count + 8'd1;
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    buf_re[slot_pos(3'(k))] <= bin_real_flat[k*DW +: DW];
                    buf_im[slot_pos(3'(k))] <= bin_imag_flat[k*DW +: DW];
                end
                state     <= STREAM;
                out_valid <= 1'b1;
                out_index <= 3'd0;
                out_real  <= sel_re;
                out_imag  <= sel_im;
                out_mag   <= sel_mag;
            end else if (xfer) begin
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_index <= 3'd0;
                end else begin
                    out_index <= nxt;
                    out_real  <= sel_re;
                    out_imag  <= sel_im;
                    out_mag   <= sel_mag;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed bench for fft_bin_streamer: reorder, magnitude, back-pressure,
// back-to-back frames and async reset.
module tb_fft_bin_streamer;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_valid;
    logic               out_ready;
    logic [87:0]        fr;
    logic [87:0]        fi;
    logic               frame_ready;
    logic               out_valid;
    logic [2:0]         out_index;
    logic signed [10:0] out_real;
    logic signed [10:0] out_imag;
    logic [11:0]        out_mag;
    logic               out_last;
    logic [7:0]         frame_count;
    logic               z_ready;
    logic               z_valid;
    logic [2:0]         z_index;
    logic signed [10:0] z_real;
    logic signed [10:0] z_imag;
    logic [11:0]        z_mag;
    logic               z_last;
    logic [7:0]         z_count;

    int                 cmps = 0;
    int                 errs = 0;
    int                 br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic signed [10:0] er [8];
    logic signed [10:0] ei [8];
    logic [11:0]        em [8];
    logic signed [10:0] er0 [8];
    bit                 chk0 = 1'b0;
    int                 cnt;
    bit                 stall;
    logic [2:0]         pidx;
    logic signed [10:0] pre;
    logic [11:0]        pmag;

    always #5 clk = ~clk;

    fft_bin_streamer #(.BITREV(1)) dut (
        .clk(clk), .rst(rst),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .bin_real_flat(fr), .bin_imag_flat(fi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_real(out_real), .out_imag(out_imag),
        .out_mag(out_mag), .out_last(out_last), .frame_count(frame_count)
    );

    fft_bin_streamer #(.BITREV(0)) dut0 (
        .clk(clk), .rst(rst),
        .frame_valid(frame_valid), .frame_ready(z_ready),
        .bin_real_flat(fr), .bin_imag_flat(fi),
        .out_valid(z_valid), .out_ready(out_ready),
        .out_index(z_index), .out_real(z_real), .out_imag(z_imag),
        .out_mag(z_mag), .out_last(z_last), .frame_count(z_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int k, input int re, input int im);
        fr[k*11 +: 11] = 11'(re);
        fi[k*11 +: 11] = 11'(im);
    endtask

    task automatic accept_frame();
        frame_valid = 1'b1;
        #1;
        chk("ready_idle", 32'(frame_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beats(input string tag);
        for (int n = 0; n < 8; n++) begin
            chk({tag, "_valid"}, 32'(out_valid), 1);
            chk({tag, "_index"}, 32'(out_index), 32'(n));
            chk({tag, "_re"}, 32'(out_real), 32'(er[n]));
            chk({tag, "_im"}, 32'(out_imag), 32'(ei[n]));
            chk({tag, "_mag"}, 32'(out_mag), 32'(em[n]));
            chk({tag, "_last"}, 32'(out_last), 32'(n == 7));
            chk({tag, "_fready"}, 32'(frame_ready), 32'(n == 7));
            if (chk0) begin
                chk({tag, "_nat_index"}, 32'(z_index), 32'(n));
                chk({tag, "_nat_re"}, 32'(z_real), 32'(er0[n]));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic impulse_setup();
        for (int k = 0; k < 8; k++) begin
            set_slot(k, 10, 0);
            er[k] = 11'sd10;
            ei[k] = 11'sd0;
            em[k] = 12'd10;
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_valid = 1'b0;
        out_ready   = 1'b1;
        fr          = '0;
        fi          = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fready", 32'(frame_ready), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_index", 32'(out_index), 0);
        chk("rst_re", 32'(out_real), 0);
        chk("rst_mag", 32'(out_mag), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_count", 32'(frame_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // impulse
        impulse_setup();
        accept_frame();
        frame_valid = 1'b0;
        expect_beats("imp");
        chk("imp_done_valid", 32'(out_valid), 0);
        chk("imp_count", 32'(frame_count), 1);

        // bit-reversed reorder, BITREV=0 instance checked alongside
        for (int k = 0; k < 8; k++) set_slot(k, k, -k);
        er = '{11'sd0, 11'sd4, 11'sd2, 11'sd6, 11'sd1, 11'sd5, 11'sd3, 11'sd7};
        ei = '{11'sd0, -11'sd4, -11'sd2, -11'sd6, -11'sd1, -11'sd5, -11'sd3, -11'sd7};
        em = '{12'd0, 12'd6, 12'd3, 12'd9, 12'd1, 12'd7, 12'd4, 12'd10};
        er0 = '{11'sd0, 11'sd1, 11'sd2, 11'sd3, 11'sd4, 11'sd5, 11'sd6, 11'sd7};
        chk0 = 1'b1;
        accept_frame();
        frame_valid = 1'b0;
        expect_beats("rev");
        chk0 = 1'b0;
        chk("rev_count", 32'(frame_count), 2);

        // magnitude extremes
        fr = '0;
        fi = '0;
        set_slot(0, -1024, -1024);
        set_slot(4, 0, -1024);
        set_slot(2, 7, 3);
        for (int n = 0; n < 8; n++) begin
            er[n] = 11'sd0;
            ei[n] = 11'sd0;
            em[n] = 12'd0;
        end
        er[0] = -11'sd1024; ei[0] = -11'sd1024; em[0] = 12'd1536;
        er[1] = 11'sd0;     ei[1] = -11'sd1024; em[1] = 12'd1024;
        er[2] = 11'sd7;     ei[2] = 11'sd3;     em[2] = 12'd8;
        accept_frame();
        frame_valid = 1'b0;
        expect_beats("mag");
        chk("mag_count", 32'(frame_count), 3);

        // back-pressure with ready pattern 1,0,0
        for (int k = 0; k < 8; k++) set_slot(k, k + 1, 0);
        for (int n = 0; n < 8; n++) er[n] = 11'(br[n] + 1);
        accept_frame();
        frame_valid = 1'b1;
        cnt   = 0;
        stall = 1'b0;
        for (int c = 0; c < 40 && cnt < 8; c++) begin
            out_ready = (c % 3 == 0);
            #1;
            chk("bp_valid", 32'(out_valid), 1);
            if (stall) begin
                chk("bp_hold_index", 32'(out_index), 32'(pidx));
                chk("bp_hold_re", 32'(out_real), 32'(pre));
                chk("bp_hold_mag", 32'(out_mag), 32'(pmag));
            end
            chk("bp_fready", 32'(frame_ready), 32'(cnt == 7 && out_ready));
            if (out_ready) begin
                chk("bp_index", 32'(out_index), 32'(cnt));
                chk("bp_re", 32'(out_real), 32'(er[cnt]));
                cnt++;
                stall = 1'b0;
                if (cnt == 8) frame_valid = 1'b0;
            end else begin
                stall = 1'b1;
                pidx  = out_index;
                pre   = out_real;
                pmag  = out_mag;
            end
            @(posedge clk);
            #1;
        end
        frame_valid = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("bp_beats", 32'(cnt), 8);
        chk("bp_done_valid", 32'(out_valid), 0);
        chk("bp_count", 32'(frame_count), 4);

        // back-to-back: frame B waits on frame_valid until A's last beat
        for (int k = 0; k < 8; k++) set_slot(k, k, 0);
        for (int n = 0; n < 8; n++) begin
            er[n] = 11'(br[n]);
            ei[n] = 11'sd0;
            em[n] = 12'(br[n]);
        end
        accept_frame();
        for (int k = 0; k < 8; k++) set_slot(k, 100 + k, 0);
        expect_beats("b2b_a");
        frame_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            er[n] = 11'(100 + br[n]);
            em[n] = 12'(100 + br[n]);
        end
        expect_beats("b2b_b");
        chk("b2b_done_valid", 32'(out_valid), 0);
        chk("b2b_count", 32'(frame_count), 6);

        // async reset mid-frame
        for (int k = 0; k < 8; k++) set_slot(k, 50 + k, 1);
        accept_frame();
        frame_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("ar_pre_index", 32'(out_index), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_index", 32'(out_index), 0);
        chk("ar_re", 32'(out_real), 0);
        chk("ar_im", 32'(out_imag), 0);
        chk("ar_mag", 32'(out_mag), 0);
        chk("ar_fready", 32'(frame_ready), 1);
        chk("ar_count", 32'(frame_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        impulse_setup();
        accept_frame();
        frame_valid = 1'b0;
        expect_beats("ar_next");
        chk("ar_next_count", 32'(frame_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
